zpu_irq_ctrl: RTL and testbench

- Parametrised, vectored, multi-channel interrupt controller for the pipelined ZPU core.
- Replaces the single external irq line with num_irq prioritised sources and drives the core's cpu_irq / interuptadr / interrutack / exitint handshake.
- Software configures it through a pipelined Wishbone slave port on the data bus.

---
 rtl/zpu_irq_pkg.sv | 37 +++
 rtl/zpu_irq_ctrl_if.sv | 21 ++
 rtl/zpu_irq_prio_enc.sv | 22 ++
 rtl/zpu_irq_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_zpu_irq_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/zpu_irq_pkg.sv
// Shared constants and types for the ZPU vectored interrupt controller.
// Register indices, FSM state encodings and the STATUS word layout.
package zpu_irq_pkg;

  localparam int ID_W = 6;
  localparam int SP_W = 4;

  localparam logic [2:0] REG_ENABLE  = 3'd0;
  localparam logic [2:0] REG_PENDING = 3'd1;
  localparam logic [2:0] REG_VECBASE = 3'd2;
  localparam logic [2:0] REG_CTRL    = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;

  typedef logic [1:0] irq_state_t;
  localparam irq_state_t ST_IDLE   = 2'd0;
  localparam irq_state_t ST_REQ    = 2'd1;
  localparam irq_state_t ST_ACTIVE = 2'd2;

  localparam int STAT_ID_LSB     = 0;
  localparam int STAT_ACTIVE_BIT = 8;
  localparam int STAT_REQ_BIT    = 9;
  localparam int STAT_LVL_LSB    = 12;

  function automatic logic [31:0] pack_status(input logic [ID_W-1:0] id,
                                              input logic active,
                                              input logic req,
                                              input logic [SP_W-1:0] lvl);
    logic [31:0] w;
    w = 32'd0;
    w[STAT_ID_LSB +: ID_W]  = id;
    w[STAT_ACTIVE_BIT]      = active;
    w[STAT_REQ_BIT]         = req;
    w[STAT_LVL_LSB +: SP_W] = lvl;
    return w;
  endfunction

endpackage

// File: rtl/zpu_irq_ctrl_if.sv
// Pipelined Wishbone slave bundle for the interrupt controller register port.
interface zpu_irq_ctrl_if;
  logic [4:0]  wb_adr_s;
  logic [31:0] wb_in_s;
  logic [31:0] wb_out_s;
  logic        wb_cyc_s;
  logic        wb_stb_s;
  logic        wb_we_s;
  logic        wb_ack_s;
  logic        wb_stall_s;

  modport slave (
    input  wb_adr_s, wb_in_s, wb_cyc_s, wb_stb_s, wb_we_s,
    output wb_out_s, wb_ack_s, wb_stall_s
  );

  modport master (
    output wb_adr_s, wb_in_s, wb_cyc_s, wb_stb_s, wb_we_s,
    input  wb_out_s, wb_ack_s, wb_stall_s
  );
endinterface

// File: rtl/zpu_irq_prio_enc.sv
// Lowest-index-wins priority encoder over the interrupt candidate vector.
module zpu_irq_prio_enc
  import zpu_irq_pkg::*;
#(
  parameter int num_irq = 8
) (
  input  logic [num_irq-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  // Scan from the top down so the lowest asserted index is the last to win.
  always_comb begin
    valid = 1'b0;
    id    = {ID_W{1'b0}};
    for (int i = num_irq - 1; i >= 0; i--) begin
      valid = valid | req[i];
      id    = req[i] ? ID_W'(i) : id;
    end
  end

endmodule

// File: rtl/zpu_irq_ctrl.sv
// Vectored multi-channel interrupt controller for the pipelined ZPU core.
// Optional nested preemption is enabled by defining ZPU_IRQ_NEST_EN.
module zpu_irq_ctrl
  import zpu_irq_pkg::*;
#(
  parameter int          num_irq     = 8,
  parameter int          pc_bit_size = 25,
  parameter int          vec_shift   = 4,
  parameter logic [31:0] edge_mask   = 32'h0,
  parameter int          nest_depth  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  zpu_irq_ctrl_if.slave          wb,
  input  logic [num_irq-1:0]     irq_src,
  output logic                   cpu_irq,
  output logic [pc_bit_size-1:0] interuptadr,
  input  logic                   interrutack,
  input  logic                   exitint
);

  localparam logic [num_irq-1:0] EDGE_MASK = edge_mask[num_irq-1:0];

  logic [num_irq-1:0]     sync1_r, sync2_r, prev_r;
  logic [num_irq-1:0]     rise_s, clr_s, pending_nx_s, cand_s;
  logic [num_irq-1:0]     pending_r, enable_r;
  logic [pc_bit_size-1:0] vecbase_r, vec_r, win_vec_s;
  logic                   gie_r;
  logic                   win_valid_s;
  logic [ID_W-1:0]        win_id_s, id_r, active_id_r;
  irq_state_t             state_r;
  logic                   cpu_irq_r, take_s;
  logic                   wb_req_s, wb_wr_s;
  logic [2:0]             reg_idx_s;
  logic                   ack_r;
  logic [31:0]            dout_r, rd_data_s;
  logic [SP_W-1:0]        lvl_s;
  logic                   unused_s;

  function automatic logic [pc_bit_size-1:0] calc_vec(input logic [pc_bit_size-1:0] base,
                                                      input logic [ID_W-1:0] id);
    logic [pc_bit_size-1:0] ext;
    ext = pc_bit_size'(id);
    return base + (ext << vec_shift);
  endfunction

  assign wb_req_s  = wb.wb_cyc_s & wb.wb_stb_s;
  assign wb_wr_s   = wb_req_s & wb.wb_we_s;
  assign reg_idx_s = wb.wb_adr_s[4:2];
  assign take_s    = (state_r == ST_REQ) & interrutack;
  assign rise_s    = sync2_r & ~prev_r;
  assign cand_s    = gie_r ? (pending_r & enable_r) : {num_irq{1'b0}};
  assign win_vec_s = calc_vec(vecbase_r, win_id_s);
  assign unused_s  = ^{wb.wb_adr_s[1:0], wb.wb_in_s};

  zpu_irq_prio_enc #(.num_irq(num_irq)) u_prio (
    .req   (cand_s),
    .valid (win_valid_s),
    .id    (win_id_s)
  );

  // Two-flop synchroniser plus one history stage for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= {num_irq{1'b0}};
      sync2_r <= {num_irq{1'b0}};
      prev_r  <= {num_irq{1'b0}};
    end else begin
      sync1_r <= irq_src;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Edge bits: clear from software or acknowledge, a new edge always wins.
  always_comb begin
    clr_s = {num_irq{1'b0}};
    for (int i = 0; i < num_irq; i++) begin
      clr_s[i] = take_s && (id_r == ID_W'(i));
    end
    if (wb_wr_s && (reg_idx_s == REG_PENDING)) begin
      clr_s = clr_s | wb.wb_in_s[num_irq-1:0];
    end else begin
      clr_s = clr_s;
    end
    pending_nx_s = (((pending_r & ~clr_s) | rise_s) & EDGE_MASK) | (sync2_r & ~EDGE_MASK);
  end

`ifdef ZPU_IRQ_NEST_EN
  logic [ID_W-1:0] stack_r [nest_depth];
  logic [SP_W-1:0] sp_r;
  logic [ID_W-1:0] pop_id_s;
  logic            push_s, pop_s;

  assign push_s = (state_r == ST_ACTIVE) && !exitint && win_valid_s &&
                  (win_id_s < active_id_r) && (sp_r < SP_W'(nest_depth));
  assign pop_s  = (state_r == ST_ACTIVE) && exitint && (sp_r != {SP_W{1'b0}});
  assign lvl_s  = sp_r;

  // Select the entry on top of the preemption stack.
  always_comb begin
    pop_id_s = {ID_W{1'b0}};
    for (int i = 0; i < nest_depth; i++) begin
      pop_id_s = (sp_r == SP_W'(i + 1)) ? stack_r[i] : pop_id_s;
    end
  end

  // Preemption stack holding interrupted active ids.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_r <= {SP_W{1'b0}};
      for (int i = 0; i < nest_depth; i++) stack_r[i] <= {ID_W{1'b0}};
    end else if (pop_s) begin
      sp_r <= sp_r - SP_W'(1);
    end else if (push_s) begin
      sp_r <= sp_r + SP_W'(1);
      for (int i = 0; i < nest_depth; i++) begin
        if (sp_r == SP_W'(i)) stack_r[i] <= active_id_r;
      end
    end
  end
`else
  localparam int unused_nest_depth = nest_depth;
  assign lvl_s = {SP_W{1'b0}};
`endif

  // Configuration registers and pending state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_r  <= {num_irq{1'b0}};
      pending_r <= {num_irq{1'b0}};
      vecbase_r <= {pc_bit_size{1'b0}};
      gie_r     <= 1'b0;
    end else begin
      pending_r <= pending_nx_s;
      if (wb_wr_s && (reg_idx_s == REG_ENABLE))  enable_r  <= wb.wb_in_s[num_irq-1:0];
      if (wb_wr_s && (reg_idx_s == REG_VECBASE)) vecbase_r <= wb.wb_in_s[pc_bit_size-1:0];
      if (wb_wr_s && (reg_idx_s == REG_CTRL))    gie_r     <= wb.wb_in_s[0];
    end
  end

  // Register read multiplexer.
  always_comb begin
    case (reg_idx_s)
      REG_ENABLE:  rd_data_s = 32'(enable_r);
      REG_PENDING: rd_data_s = 32'(pending_r);
      REG_VECBASE: rd_data_s = 32'(vecbase_r);
      REG_CTRL:    rd_data_s = {31'd0, gie_r};
      REG_STATUS:  rd_data_s = pack_status(active_id_r, state_r == ST_ACTIVE, cpu_irq_r, lvl_s);
      default:     rd_data_s = 32'd0;
    endcase
  end

  // Zero-wait-state acknowledge with read data registered alongside it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_r  <= 1'b0;
      dout_r <= 32'd0;
    end else begin
      ack_r <= wb_req_s;
      if (wb_req_s && !wb.wb_we_s) dout_r <= rd_data_s;
    end
  end

  // Request/acknowledge/return handshake with the core; vector frozen in REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cpu_irq_r   <= 1'b0;
      vec_r       <= {pc_bit_size{1'b0}};
      id_r        <= {ID_W{1'b0}};
      active_id_r <= {ID_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_valid_s) begin
            state_r   <= ST_REQ;
            cpu_irq_r <= 1'b1;
            id_r      <= win_id_s;
            vec_r     <= win_vec_s;
          end
        end
        ST_REQ: begin
          if (interrutack) begin
            state_r     <= ST_ACTIVE;
            cpu_irq_r   <= 1'b0;
            active_id_r <= id_r;
          end
        end
        ST_ACTIVE: begin
`ifdef ZPU_IRQ_NEST_EN
          if (pop_s) begin
            active_id_r <= pop_id_s;
          end else if (exitint) begin
            state_r <= ST_IDLE;
          end else if (push_s) begin
            state_r   <= ST_REQ;
            cpu_irq_r <= 1'b1;
            id_r      <= win_id_s;
            vec_r     <= win_vec_s;
          end
`else
          if (exitint) state_r <= ST_IDLE;
`endif
        end
        default: begin
          state_r   <= ST_IDLE;
          cpu_irq_r <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_irq       = cpu_irq_r;
  assign interuptadr   = vec_r;
  assign wb.wb_out_s   = dout_r;
  assign wb.wb_ack_s   = ack_r;
  assign wb.wb_stall_s = 1'b0;

endmodule

// File: tb/tb_zpu_irq_ctrl.sv
// Scoreboard bench for zpu_irq_ctrl: expected read data and vectors are queued
// by the stimulus and consumed by monitors when the DUT acks or raises cpu_irq.
module tb_zpu_irq_ctrl;
  import zpu_irq_pkg::*;

  localparam int          NI  = 8;
  localparam int          PCW = 25;
  localparam logic [31:0] EM  = 32'h25;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NI-1:0]  irq_src = '0;
  logic           interrutack = 1'b0;
  logic           exitint = 1'b0;
  logic           cpu_irq;
  logic [PCW-1:0] interuptadr;

  always #5 clk = ~clk;

  zpu_irq_ctrl_if wb_if();

  zpu_irq_ctrl #(.num_irq(NI), .pc_bit_size(PCW), .vec_shift(4), .edge_mask(EM), .nest_depth(4)) dut (
    .clk(clk), .rst(rst), .wb(wb_if), .irq_src(irq_src), .cpu_irq(cpu_irq),
    .interuptadr(interuptadr), .interrutack(interrutack), .exitint(exitint)
  );

  typedef struct {
    logic        is_rd;
    logic [31:0] exp;
    string       name;
  } wb_exp_t;

  wb_exp_t        rd_q[$];
  logic [PCW-1:0] vec_q[$];
  int             n_pass = 0;
  int             n_total = 0;
  wb_exp_t        mon_e;
  logic           irq_prev = 1'b0;
  logic [PCW-1:0] cur_vec = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Wishbone monitor: every ack consumes one queued transaction.
  always @(negedge clk) begin
    if (rst && wb_if.wb_ack_s) begin
      if (rd_q.size() == 0) begin
        check("wb_unexpected_ack", 32'(wb_if.wb_ack_s), 32'd0);
      end else begin
        mon_e = rd_q.pop_front();
        if (mon_e.is_rd) check(mon_e.name, wb_if.wb_out_s, mon_e.exp);
      end
    end
  end

  // Interrupt monitor: each rising cpu_irq consumes one queued vector, held until dropped.
  always @(negedge clk) begin
    if (cpu_irq && !irq_prev) begin
      if (vec_q.size() == 0) begin
        check("irq_unexpected", 32'(cpu_irq), 32'd0);
        cur_vec = '1;
      end else begin
        cur_vec = vec_q.pop_front();
        check("irq_vector", 32'(interuptadr), 32'(cur_vec));
      end
    end else if (cpu_irq && irq_prev) begin
      check("irq_vector_hold", 32'(interuptadr), 32'(cur_vec));
    end
    irq_prev = cpu_irq;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [2:0] idx, input logic [31:0] d);
    rd_q.push_back('{is_rd: 1'b0, exp: 32'd0, name: "wr"});
    @(posedge clk); #1;
    wb_if.wb_cyc_s = 1'b1; wb_if.wb_stb_s = 1'b1; wb_if.wb_we_s = 1'b1;
    wb_if.wb_adr_s = {idx, 2'b00}; wb_if.wb_in_s = d;
    @(posedge clk); #1;
    wb_if.wb_cyc_s = 1'b0; wb_if.wb_stb_s = 1'b0; wb_if.wb_we_s = 1'b0;
  endtask

  task automatic wb_read(input logic [2:0] idx, input logic [31:0] exp, input string nm);
    rd_q.push_back('{is_rd: 1'b1, exp: exp, name: nm});
    @(posedge clk); #1;
    wb_if.wb_cyc_s = 1'b1; wb_if.wb_stb_s = 1'b1; wb_if.wb_we_s = 1'b0;
    wb_if.wb_adr_s = {idx, 2'b00};
    @(posedge clk); #1;
    wb_if.wb_cyc_s = 1'b0; wb_if.wb_stb_s = 1'b0;
  endtask

  task automatic wait_irq(input int max, input string nm);
    int n;
    n = 0;
    while (!cpu_irq && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check(nm, 32'(cpu_irq), 32'd1);
  endtask

  task automatic ack_pulse(input string nm);
    @(posedge clk); #1; interrutack = 1'b1;
    @(posedge clk); #1; interrutack = 1'b0;
    check(nm, 32'(cpu_irq), 32'd0);
  endtask

  task automatic exit_pulse();
    @(posedge clk); #1; exitint = 1'b1;
    @(posedge clk); #1; exitint = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    wb_if.wb_cyc_s = 1'b0; wb_if.wb_stb_s = 1'b0; wb_if.wb_we_s = 1'b0;
    wb_if.wb_adr_s = 5'd0; wb_if.wb_in_s = 32'd0;
    idle(3);
    check("rst_cpu_irq", 32'(cpu_irq), 32'd0);
    check("rst_vector", 32'(interuptadr), 32'd0);
    check("rst_ack", 32'(wb_if.wb_ack_s), 32'd0);
    check("rst_dout", wb_if.wb_out_s, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Level channel 3.
    wb_write(REG_VECBASE, 32'h100);
    wb_write(REG_ENABLE, 32'h08);
    wb_write(REG_CTRL, 32'h1);
    vec_q.push_back(25'h130);
    irq_src[3] = 1'b1;
    wait_irq(4, "t1_irq_within_4");
    wb_read(REG_STATUS, 32'h200, "t1_status_req");
    ack_pulse("t1_ack_drops_irq");
    wb_read(REG_STATUS, 32'h103, "t1_status_active");
    irq_src[3] = 1'b0;
    idle(5);
    exit_pulse();
    idle(4);
    wb_read(REG_PENDING, 32'h0, "t1_pending_clear");

    // Edge channel 0 pulsed while disabled.
    wb_write(REG_ENABLE, 32'h0);
    irq_src[0] = 1'b1; idle(2); irq_src[0] = 1'b0; idle(4);
    wb_read(REG_PENDING, 32'h1, "t2_pending_latched");
    vec_q.push_back(25'h100);
    wb_write(REG_ENABLE, 32'h1);
    wait_irq(8, "t2_irq");
    wb_write(REG_PENDING, 32'h1);
    wb_read(REG_PENDING, 32'h0, "t2_pending_w1c");
    check("t2_req_held", 32'(cpu_irq), 32'd1);
    ack_pulse("t2_ack_drops_irq");
    idle(2);
    exit_pulse();
    idle(4);
    exit_pulse();
    ack_pulse("t2_stray_ack_idle");
    wb_read(REG_STATUS, 32'h000, "t2_status_idle");

    // Simultaneous edges on 5 and 2; 0 arrives during REQ.
    wb_write(REG_ENABLE, 32'h25);
    vec_q.push_back(25'h120);
    irq_src[5] = 1'b1; irq_src[2] = 1'b1;
    wait_irq(8, "t3_irq_ch2");
    irq_src[0] = 1'b1;
    idle(5);
    ack_pulse("t3_ack_ch2");
    wb_read(REG_PENDING, 32'h21, "t3_pending_after_ack");
    vec_q.push_back(25'h100);
    exit_pulse();
    wait_irq(8, "t3_irq_ch0");
    ack_pulse("t3_ack_ch0");
    wb_read(REG_PENDING, 32'h20, "t3_pending_ch5_left");
    vec_q.push_back(25'h150);
    exit_pulse();
    wait_irq(8, "t3_irq_ch5");
    ack_pulse("t3_ack_ch5");
    exit_pulse();
    irq_src = '0;
    idle(4);
    wb_read(REG_PENDING, 32'h0, "t3_pending_empty");

    // Back-to-back reads with strobe held.
    rd_q.push_back('{is_rd: 1'b1, exp: 32'h25, name: "t4_burst_enable"});
    rd_q.push_back('{is_rd: 1'b1, exp: 32'h100, name: "t4_burst_vecbase"});
    rd_q.push_back('{is_rd: 1'b1, exp: 32'h0, name: "t4_burst_idx7"});
    @(posedge clk); #1;
    wb_if.wb_cyc_s = 1'b1; wb_if.wb_stb_s = 1'b1; wb_if.wb_we_s = 1'b0;
    wb_if.wb_adr_s = {REG_ENABLE, 2'b00};
    @(posedge clk); #1;
    wb_if.wb_adr_s = {REG_VECBASE, 2'b00};
    check("t4_stall", 32'(wb_if.wb_stall_s), 32'd0);
    @(posedge clk); #1;
    wb_if.wb_adr_s = 5'b11100;
    check("t4_ack_mid_burst", 32'(wb_if.wb_ack_s), 32'd1);
    @(posedge clk); #1;
    wb_if.wb_cyc_s = 1'b0; wb_if.wb_stb_s = 1'b0;
    wb_read(3'd5, 32'h0, "t4_idx5_zero");
    wb_read(REG_CTRL, 32'h1, "t4_ctrl");

    // Asynchronous reset in the middle of a request.
    wb_write(REG_ENABLE, 32'h08);
    vec_q.push_back(25'h130);
    irq_src[3] = 1'b1;
    wait_irq(8, "t5_irq");
    @(negedge clk); #2; rst = 1'b0; #1;
    check("t5_async_cpu_irq", 32'(cpu_irq), 32'd0);
    check("t5_async_vector", 32'(interuptadr), 32'd0);
    idle(2);
    @(negedge clk); rst = 1'b1;
    idle(6);
    wb_read(REG_ENABLE, 32'h0, "t5_enable_reset");
    wb_read(REG_VECBASE, 32'h0, "t5_vecbase_reset");
    wb_read(REG_CTRL, 32'h0, "t5_gie_reset");
    irq_src = '0;
    idle(4);

`ifdef ZPU_IRQ_NEST_EN
    // Channel 1 preempts active channel 4.
    wb_write(REG_VECBASE, 32'h100);
    wb_write(REG_ENABLE, 32'h12);
    wb_write(REG_CTRL, 32'h1);
    vec_q.push_back(25'h140);
    irq_src[4] = 1'b1;
    wait_irq(8, "n_irq_ch4");
    ack_pulse("n_ack_ch4");
    vec_q.push_back(25'h110);
    irq_src[1] = 1'b1;
    wait_irq(8, "n_irq_ch1");
    wb_read(REG_STATUS, 32'h1204, "n_status_preempt");
    ack_pulse("n_ack_ch1");
    wb_read(REG_STATUS, 32'h1101, "n_status_ch1_active");
    irq_src[1] = 1'b0;
    idle(5);
    exit_pulse();
    wb_read(REG_STATUS, 32'h0104, "n_status_back_ch4");
    irq_src[4] = 1'b0;
    idle(5);
    exit_pulse();
    idle(3);
    wb_read(REG_STATUS, 32'h0004, "n_status_idle");
`endif

    idle(4);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("vec_q_drained", 32'(vec_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
